// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder: packs field-level RV32I requests into 32-bit instruction words and
// streams them into an instruction-memory write port, one word per accepted request.
//
// Optional build macro: ENC_CHECK_EN
//   defined   : malformed requests are dropped and flagged with a one-cycle err pulse
//   undefined : err is held at 0; immediates are truncated to their field width;
//               illegal classes are written as NOP (0x00000013)
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             pulse: open/reopen a load session at BASE_ADDR
//   in_valid/in_ready request handshake (in_ready is registered)
//   in_class..in_imm  instruction fields (class, funct3, funct7[5], rd, rs1, rs2, imm)
//   wr_en/addr/data   registered imem write port
//   count, full       words written this session, session full flag
//   err               pulse: request rejected
module rv_instr_encoder #(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [20:0]       in_imm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [2:0] CLS_R      = 3'd0;
    localparam logic [2:0] CLS_I      = 3'd1;
    localparam logic [2:0] CLS_LOAD   = 3'd2;
    localparam logic [2:0] CLS_STORE  = 3'd3;
    localparam logic [2:0] CLS_BRANCH = 3'd4;
    localparam logic [2:0] CLS_JAL    = 3'd5;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FULL
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                full_q, full_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic                err_q, err_d;

    logic                hs_c;
    logic [31:0]         enc_c;
    logic                bad_c;

    assign hs_c = in_valid & in_ready_q;

    // Field packing; immediates take only the bits their format carries.
    always_comb begin
        enc_c = NOP_WORD;
        unique case (in_class)
            CLS_R:      enc_c = {1'b0, in_funct7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            CLS_I:      enc_c = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
            CLS_LOAD:   enc_c = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
            CLS_STORE:  enc_c = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
            CLS_BRANCH: enc_c = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                 in_imm[4:1], in_imm[11], 7'b1100011};
            CLS_JAL:    enc_c = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                 in_rd, 7'b1101111};
            default:    enc_c = NOP_WORD;
        endcase
    end

`ifdef ENC_CHECK_EN
    // Range checks: upper immediate bits must be pure sign extension of the field.
    logic imm_fits12_c;
    logic imm_fits13_c;
    assign imm_fits12_c = (in_imm[20:11] == 10'h000) || (in_imm[20:11] == 10'h3FF);
    assign imm_fits13_c = (in_imm[20:12] == 9'h000)  || (in_imm[20:12] == 9'h1FF);

    always_comb begin
        bad_c = 1'b0;
        unique case (in_class)
            CLS_R:      bad_c = in_funct7b5 && (in_funct3 != 3'b000) && (in_funct3 != 3'b101);
            CLS_I,
            CLS_LOAD,
            CLS_STORE:  bad_c = !imm_fits12_c;
            CLS_BRANCH: bad_c = !imm_fits13_c || in_imm[0];
            CLS_JAL:    bad_c = in_imm[0];
            default:    bad_c = 1'b1;
        endcase
    end
`else
    assign bad_c = 1'b0;
`endif

    // Session control and write-port next state; start is applied before a same-cycle beat.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = 1'b0;

        if (start) begin
            state_d = S_LOAD;
            ptr_d   = ADDR_W'(BASE_ADDR);
            cnt_d   = '0;
        end

        if (hs_c) begin
            if (bad_c) begin
                err_d = 1'b1;
            end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_d;
                wr_data_d = enc_c;
                ptr_d     = ptr_d + ADDR_W'(1);
                cnt_d     = cnt_d + CNT_W'(1);
            end
        end

        full_d = (cnt_d == CNT_W'(DEPTH));
        if ((state_d == S_LOAD) && full_d) begin
            state_d = S_FULL;
        end
        in_ready_d = (state_d == S_LOAD) && !full_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= ADDR_W'(BASE_ADDR);
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            full_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= ADDR_W'(BASE_ADDR);
            wr_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            full_q     <= full_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            err_q      <= err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign count    = cnt_q;
    assign full     = full_q;
    assign err      = err_q;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed bench for rv_instr_encoder with a 4-word memory (ADDR_W = 2).
module tb_rv_instr_encoder;

    localparam int unsigned ADDR_W = 2;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_class;
    logic [2:0]        in_funct3;
    logic              in_funct7b5;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [20:0]       in_imm;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;

    int checks;
    int failures;

    rv_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_class    (in_class),
        .in_funct3   (in_funct3),
        .in_funct7b5 (in_funct7b5),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .count       (count),
        .full        (full),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] cls, input logic [2:0] f3, input logic f7b5,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input int imm);
        in_class    = cls;
        in_funct3   = f3;
        in_funct7b5 = f7b5;
        in_rd       = rd;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_imm      = 21'(imm);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got %0b exp 0", in_ready); end
        checks++; if (wr_en !== 1'b0)    begin failures++; $display("FAIL reset_wr_en got %0b exp 0", wr_en); end
        checks++; if (wr_addr !== 2'd0)  begin failures++; $display("FAIL reset_wr_addr got %0d exp 0", wr_addr); end
        checks++; if (wr_data !== 32'h0) begin failures++; $display("FAIL reset_wr_data got %h exp 0", wr_data); end
        checks++; if (count !== 3'd0 || full !== 1'b0 || err !== 1'b0) begin
            failures++; $display("FAIL reset_cnt_full_err got %0d/%0b/%0b exp 0/0/0", count, full, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL idle_in_ready got %0b exp 0", in_ready); end
    endtask

    task automatic test_r_i_type();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h002081B3;
        exp_w[1] = 32'h402081B3;
        exp_w[2] = 32'hFFF00293;
        pulse_start();
        checks++; if (in_ready !== 1'b1 || count !== 3'd0) begin
            failures++; $display("FAIL start_open got rdy=%0b cnt=%0d exp 1/0", in_ready, count);
        end
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       set_req(3'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 0);
                1:       set_req(3'd0, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 0);
                default: set_req(3'd1, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, -1);
            endcase
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== 2'(i) || wr_data !== exp_w[i]) begin
                failures++;
                $display("FAIL ri_beat%0d got en=%0b addr=%0d data=%h exp 1/%0d/%h",
                         i, wr_en, wr_addr, wr_data, i, exp_w[i]);
            end
        end
        step();
        checks++; if (wr_en !== 1'b0 || count !== 3'd3) begin
            failures++; $display("FAIL ri_idle got en=%0b cnt=%0d exp 0/3", wr_en, count);
        end
    endtask

    task automatic test_s_b_j();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h0020A423;
        exp_w[1] = 32'h00208463;
        exp_w[2] = 32'h010000EF;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       set_req(3'd3, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 8);
                1:       set_req(3'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 8);
                default: set_req(3'd5, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 16);
            endcase
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== 2'(i) || wr_data !== exp_w[i]) begin
                failures++;
                $display("FAIL sbj_beat%0d got en=%0b addr=%0d data=%h exp 1/%0d/%h",
                         i, wr_en, wr_addr, wr_data, i, exp_w[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h0040A283;   // lw x5, 4(x1)
        exp_w[1] = 32'hFE208EE3;   // beq x1, x2, -4
        exp_w[2] = 32'h002081B3;   // add x3, x1, x2
        exp_w[3] = 32'h010000EF;   // jal x1, 16
        pulse_start();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       set_req(3'd2, 3'b010, 1'b0, 5'd5, 5'd1, 5'd0, 4);
                1:       set_req(3'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, -4);
                2:       set_req(3'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 0);
                default: set_req(3'd5, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 16);
            endcase
            step();
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== 2'(i) || wr_data !== exp_w[i] || count !== 3'(i + 1)) begin
                failures++;
                $display("FAIL b2b_beat%0d got en=%0b addr=%0d data=%h cnt=%0d exp 1/%0d/%h/%0d",
                         i, wr_en, wr_addr, wr_data, count, i, exp_w[i], i + 1);
            end
        end
        checks++; if (full !== 1'b1 || in_ready !== 1'b0) begin
            failures++; $display("FAIL full_flag got full=%0b rdy=%0b exp 1/0", full, in_ready);
        end
        step();
        checks++; if (wr_en !== 1'b0 || count !== 3'd4 || full !== 1'b1) begin
            failures++; $display("FAIL full_blocks got en=%0b cnt=%0d full=%0b exp 0/4/1", wr_en, count, full);
        end
        pulse_start();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1 || count !== 3'd0 || full !== 1'b0 || wr_en !== 1'b0) begin
            failures++; $display("FAIL reopen got rdy=%0b cnt=%0d full=%0b en=%0b exp 1/0/0/0",
                                 in_ready, count, full, wr_en);
        end
    endtask

    task automatic test_start_with_beat();
        set_req(3'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (wr_addr !== 2'd0 || count !== 3'd1) begin
            failures++; $display("FAIL pre_start_beat got addr=%0d cnt=%0d exp 0/1", wr_addr, count);
        end
        set_req(3'd0, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 0);
        start    = 1'b1;
        in_valid = 1'b1;
        step();
        start    = 1'b0;
        checks++; if (wr_en !== 1'b1 || wr_addr !== 2'd0 || count !== 3'd1 || wr_data !== 32'h402081B3) begin
            failures++; $display("FAIL start_beat got en=%0b addr=%0d cnt=%0d data=%h exp 1/0/1/402081b3",
                                 wr_en, wr_addr, count, wr_data);
        end
        step();
        in_valid = 1'b0;
        checks++; if (wr_en !== 1'b1 || wr_addr !== 2'd1 || count !== 3'd2) begin
            failures++; $display("FAIL stream_beat got en=%0b addr=%0d cnt=%0d exp 1/1/2", wr_en, wr_addr, count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (wr_en !== 1'b0 || count !== 3'd0 || in_ready !== 1'b0 || wr_data !== 32'h0) begin
            failures++; $display("FAIL async_reset got en=%0b cnt=%0d rdy=%0b data=%h exp 0/0/0/0",
                                 wr_en, count, in_ready, wr_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_illegal();
        pulse_start();
`ifdef ENC_CHECK_EN
        set_req(3'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 3);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (err !== 1'b1 || wr_en !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL b_odd_reject got err=%0b en=%0b cnt=%0d rdy=%0b exp 1/0/0/1",
                                 err, wr_en, count, in_ready);
        end
        set_req(3'd7, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (err !== 1'b1 || wr_en !== 1'b0 || count !== 3'd0) begin
            failures++; $display("FAIL class7_reject got err=%0b en=%0b cnt=%0d exp 1/0/0", err, wr_en, count);
        end
        step();
        checks++; if (err !== 1'b0) begin
            failures++; $display("FAIL err_pulse got err=%0b exp 0", err);
        end
`else
        set_req(3'd7, 3'b000, 1'b0, 5'd9, 5'd9, 5'd9, 123);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (wr_en !== 1'b1 || wr_data !== 32'h00000013 || count !== 3'd1 || err !== 1'b0) begin
            failures++; $display("FAIL class7_nop got en=%0b data=%h cnt=%0d err=%0b exp 1/00000013/1/0",
                                 wr_en, wr_data, count, err);
        end
        set_req(3'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 3);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        // Odd offset is truncated: imm[0] has no slot, so imm=3 packs like imm=2.
        checks++; if (wr_en !== 1'b1 || err !== 1'b0 || wr_data !== 32'h00208163 || wr_addr !== 2'd1) begin
            failures++; $display("FAIL b_odd_trunc got en=%0b err=%0b data=%h addr=%0d exp 1/0/00208163/1",
                                 wr_en, err, wr_data, wr_addr);
        end
`endif
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        start       = 1'b0;
        in_valid    = 1'b0;
        set_req(3'd0, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 0);
        test_reset();
        test_r_i_type();
        test_s_b_j();
        test_back_to_back();
        test_start_with_beat();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
